// File: rtl/sha_session_arb.sv
// Round-robin session arbiter for the shared SHA-256/HMAC engine: grants one
// requester at a time, forwards its word stream and scrubs the engine afterwards.
module sha_session_arb #(
  parameter int unsigned NumReq  = 2,
  parameter logic [31:0] WipeVal = 32'hDEAD_BEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_i,
  input  logic [NumReq-1:0]      req_hmac_i,
  input  logic [NumReq*64-1:0]   req_len_i,
  input  logic [NumReq-1:0]      req_process_i,
  input  logic [NumReq-1:0]      req_wvalid_i,
  input  logic [NumReq*32-1:0]   req_wdata_i,
  input  logic [NumReq*4-1:0]    req_wmask_i,
  output logic [NumReq-1:0]      req_wready_o,
  output logic [NumReq-1:0]      gnt_o,
  output logic [NumReq-1:0]      done_o,
  output logic                   abort_o,
  output logic                   busy_o,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic [31:0]            beat_cnt_o,
  output logic                   eng_hmac_en_o,
  output logic                   eng_hash_start_o,
  output logic                   eng_hash_process_o,
  input  logic                   eng_hash_done_i,
  output logic [63:0]            eng_msg_len_o,
  output logic                   eng_wvalid_o,
  output logic [31:0]            eng_wdata_o,
  output logic [3:0]             eng_wmask_o,
  input  logic                   eng_wready_i,
  output logic                   eng_wipe_o,
  output logic [31:0]            eng_wipe_v_o
);

  localparam int unsigned OW = $clog2(NumReq);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_WAIT, S_WIPE
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic          hmac_q, hmac_d;
  logic [63:0]   len_q, len_d;
  logic [31:0]   beat_q, beat_d;
  logic          aborted_q, aborted_d;
  logic          found;
  logic [OW-1:0] cand;
  logic [NumReq-1:0] owner_oh;

  logic [63:0] len_a   [NumReq];
  logic [31:0] wdata_a [NumReq];
  logic [3:0]  wmask_a [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign len_a[g]   = req_len_i[64*g +: 64];
    assign wdata_a[g] = req_wdata_i[32*g +: 32];
    assign wmask_a[g] = req_wmask_i[4*g +: 4];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      last_q    <= OW'(NumReq - 1);
      hmac_q    <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hmac_q    <= hmac_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic plus the combinational word path while streaming.
  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    last_d             = last_q;
    hmac_d             = hmac_q;
    len_d              = len_q;
    beat_d             = beat_q;
    aborted_d          = aborted_q;
    found              = 1'b0;
    cand               = '0;
    eng_hash_process_o = 1'b0;
    eng_wvalid_o       = 1'b0;
    eng_wdata_o        = '0;
    eng_wmask_o        = '0;
    req_wready_o       = '0;

    case (state_q)
      S_IDLE: begin
        // First requesting index after the previous owner wins.
        for (int i = 0; i < int'(NumReq); i++) begin
          cand = OW'((int'(last_q) + 1 + i) % int'(NumReq));
          if (!found && req_i[cand]) begin
            found   = 1'b1;
            owner_d = cand;
          end
        end
        if (found) begin
          hmac_d  = req_hmac_i[owner_d];
          len_d   = len_a[owner_d];
          state_d = S_START;
        end
      end
      S_START: begin
        beat_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        eng_wvalid_o          = req_wvalid_i[owner_q];
        eng_wdata_o           = wdata_a[owner_q];
        eng_wmask_o           = wmask_a[owner_q];
        req_wready_o[owner_q] = eng_wready_i;
        if (eng_wvalid_o && eng_wready_i) begin
          beat_d = beat_q + 32'd1;
        end
        if (req_process_i[owner_q]) begin
          eng_hash_process_o = 1'b1;
          state_d            = S_WAIT;
        end else if (!req_i[owner_q]) begin
          eng_hash_process_o = 1'b1;
          aborted_d          = 1'b1;
          state_d            = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_hash_done_i) begin
          state_d = S_WIPE;
        end
      end
      S_WIPE: begin
        last_d    = owner_q;
        aborted_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign owner_oh = NumReq'(1) << owner_q;

  // Moore outputs decoded from the registered state.
  assign busy_o           = (state_q != S_IDLE);
  assign gnt_o            = (state_q == S_START || state_q == S_STREAM || state_q == S_WAIT)
                            ? owner_oh : '0;
  assign done_o           = (state_q == S_WIPE && !aborted_q) ? owner_oh : '0;
  assign abort_o          = (state_q == S_WIPE) && aborted_q;
  assign eng_hash_start_o = (state_q == S_START);
  assign eng_hmac_en_o    = busy_o && hmac_q;
  assign eng_msg_len_o    = len_q;
  assign eng_wipe_o       = (state_q == S_WIPE);
  assign eng_wipe_v_o     = (state_q == S_WIPE) ? WipeVal : 32'd0;
  assign owner_o          = owner_q;
  assign beat_cnt_o       = beat_q;

endmodule
